// File: rtl/cntr_updn_n.sv
// ---------------------------------------------------------------------------
// cntr_updn_n -- parametrised up/down counter with modulus, parallel load,
// count enable, terminal-count output and a registered limit-event pulse.
//
// The count range is 0..MAX. When SATURATE=0 the counter wraps at the limits
// (MAX -> 0 going up, 0 -> MAX going down). When SATURATE=1 it holds at the
// limit instead. Either way, stepping against a limit raises ovf for one cycle.
// Stages cascade by feeding tc of one stage into ce of the next. All stages
// share clk, reset, pe and up.
//
// Parameters:
//   WIDTH     counter width in bits (>= 1)
//   MAX       highest count value, 1 <= MAX <= 2**WIDTH-1
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high reset (q=0, ovf=0)
//   pe     in   1      parallel load enable (takes priority over ce)
//   p      in   WIDTH  parallel load value (clamped to MAX)
//   ce     in   1      count enable
//   up     in   1      direction: 1 = increment, 0 = decrement
//   q      out  WIDTH  registered count value
//   tc     out  1      terminal count, combinational: ce & at the limit in
//                      the current direction (not gated by pe)
//   ovf    out  1      registered one-cycle limit-event pulse
// ---------------------------------------------------------------------------
module cntr_updn_n #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = (2 ** WIDTH) - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pe,
    input  logic [WIDTH-1:0] p,
    input  logic             ce,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    // Reject configurations the counter cannot represent.
    if (WIDTH < 1) begin : g_bad_width
        $error("cntr_updn_n: WIDTH must be at least 1");
    end
    if ((MAX < 1) || (MAX > (2 ** WIDTH) - 1)) begin : g_bad_max
        $error("cntr_updn_n: MAX must lie in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX_V = MAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             at_max;
    logic             at_zero;

    // Limit detection compares against MAX, not the natural 2**WIDTH rollover.
    assign at_max  = (q_q == MAX_V);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d   = q_q;
        ovf_d = 1'b0;
        if (pe) begin
            // Clamp so q can never hold a value above MAX.
            q_d = (p > MAX_V) ? MAX_V : p;
        end else if (ce) begin
            if (up) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    q_d   = SATURATE ? MAX_V : '0;
                end else begin
                    q_d = q_q + ONE_V;
                end
            end else begin
                if (at_zero) begin
                    ovf_d = 1'b1;
                    q_d   = SATURATE ? '0 : MAX_V;
                end else begin
                    q_d = q_q - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    // tc sees ce and up with zero latency so a cascade advances on the same
    // edge that wraps the lower stage.
    assign tc  = ce & (up ? at_max : at_zero);
    assign q   = q_q;
    assign ovf = ovf_q;

endmodule
